// File: rtl/cheat_pkg.sv
// Shared definitions for the cheat loader and the cheat-code matching engine:
// loader FSM states, code-word bit positions and the field byte-order helper.
package cheat_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COLLECT,
    STROBE_HI,
    STROBE_LO
  } state_e;

  // Bit positions inside the 129-bit code word seen by the engine.
  localparam int CLK_BIT   = 128;
  localparam int FLAGS_LSB = 96;
  localparam int ADDR_LSB  = 64;
  localparam int COMP_LSB  = 32;
  localparam int DATA_LSB  = 0;

  // Reorders a field held in file byte order {b0,b1,b2,b3} into {b3,b2,b1,b0}.
  function automatic logic [31:0] swap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/cheat_loader.sv
// Cheat-file loader: assembles 16-byte records from the HPS ioctl stream and
// paces them into the matching engine. Optional status ports: CHEAT_LOADER_STATUS_EN.
module cheat_loader
  import cheat_pkg::*;
#(
  parameter logic [7:0] CHEAT_INDEX = 8'd255,
  parameter int         MAX_CODES   = 32,
  parameter int         STROBE_CYC  = 4,
  parameter int         CLR_CYC     = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ioctl_download,
  input  logic [7:0]   ioctl_index,
  input  logic         ioctl_wr,
  input  logic [24:0]  ioctl_addr,
  input  logic [15:0]  ioctl_dout,
  output logic         ioctl_wait,
  output logic [128:0] code,
`ifdef CHEAT_LOADER_STATUS_EN
  output logic [$clog2(MAX_CODES+1)-1:0] code_count,
  output logic         overflow,
`endif
  output logic         codes_reset
);

  localparam int CW      = $clog2(MAX_CODES + 1);
  localparam int CNT_MAX = (CLR_CYC > STROBE_CYC) ? CLR_CYC : STROBE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [128:0]       code_q, code_d;
  logic               codes_reset_q, codes_reset_d;
  logic               wait_q, wait_d;
  logic [6:0]         mask_q, mask_d;
  logic [CW-1:0]      loaded_q, loaded_d;
  logic               pending_q, pending_d;
  logic               active_q;
`ifdef CHEAT_LOADER_STATUS_EN
  logic               overflow_q, overflow_d;
`endif

  logic [15:0]        words_q [7];
  logic [7:0][15:0]   w_all;
  logic [127:0]       rec_word;

  logic               active, start, accept, last_word, rec_done, can_load;
  logic [2:0]         slot;
  logic               unused_addr;

  assign unused_addr = ^{ioctl_addr[24:4], ioctl_addr[0]};

  assign active    = ioctl_download && (ioctl_index == CHEAT_INDEX);
  assign start     = active && !active_q;
  assign slot      = ioctl_addr[3:1];
  assign accept    = (state_q == COLLECT) && active && ioctl_wr;
  assign last_word = accept && (slot == 3'd7);
  assign rec_done  = last_word && (&mask_q);
  assign can_load  = loaded_q < CW'(MAX_CODES);

  function automatic logic [31:0] le_field(input logic [15:0] lo, input logic [15:0] hi);
    return swap32({lo[7:0], lo[15:8], hi[7:0], hi[15:8]});
  endfunction

  // The final word is used straight off the bus so the record latches on its own edge.
  always_comb begin
    for (int k = 0; k < 7; k++) w_all[k] = words_q[k];
    w_all[7] = ioctl_dout;
  end

  always_comb begin
    rec_word                    = '0;
    rec_word[FLAGS_LSB +: 32]   = le_field(w_all[0], w_all[1]);
    rec_word[ADDR_LSB  +: 32]   = le_field(w_all[2], w_all[3]);
    rec_word[COMP_LSB  +: 32]   = le_field(w_all[4], w_all[5]);
    rec_word[DATA_LSB  +: 32]   = le_field(w_all[6], w_all[7]);
  end

  // NOTE: word storage is deliberately not reset; the mask decides which
  // slots are valid, so the array maps onto plain enable flops.
  always_ff @(posedge clk) begin
    if (accept && (slot != 3'd7)) words_q[slot] <= ioctl_dout;
  end

  // NOTE: this codebase resets synchronously and active-high; all state
  // updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      code_q        <= '0;
      codes_reset_q <= 1'b0;
      wait_q        <= 1'b0;
      mask_q        <= '0;
      loaded_q      <= '0;
      pending_q     <= 1'b0;
      active_q      <= 1'b0;
`ifdef CHEAT_LOADER_STATUS_EN
      overflow_q    <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      code_q        <= code_d;
      codes_reset_q <= codes_reset_d;
      wait_q        <= wait_d;
      mask_q        <= mask_d;
      loaded_q      <= loaded_d;
      pending_q     <= pending_d;
      active_q      <= active;
`ifdef CHEAT_LOADER_STATUS_EN
      overflow_q    <= overflow_d;
`endif
    end
  end

  // NOTE: every signal written in a combinational block is given a default
  // first, so no path can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:      if (start) state_d = CLEAR;
      CLEAR:     if (cnt_q == '0) state_d = COLLECT;
      COLLECT: begin
        if (!active)                   state_d = IDLE;
        else if (rec_done && can_load) state_d = STROBE_HI;
      end
      STROBE_HI: if (cnt_q == '0) state_d = STROBE_LO;
      STROBE_LO: begin
        if (cnt_q == '0) begin
          if (pending_q || start) state_d = CLEAR;
          else if (active)        state_d = COLLECT;
          else                    state_d = IDLE;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    loaded_d  = loaded_q;
    pending_d = pending_q;
    code_d    = {1'b0, code_q[127:0]};
`ifdef CHEAT_LOADER_STATUS_EN
    overflow_d = overflow_q | (rec_done && !can_load);
`endif

    if (((state_q == STROBE_HI) || (state_q == STROBE_LO)) && start) pending_d = 1'b1;

    if (accept && (slot != 3'd7)) mask_d = mask_q | 7'(8'd1 << slot);
    if (last_word)                   mask_d = '0;
    if ((state_q == COLLECT) && !active) mask_d = '0;

    if ((state_q == COLLECT) && rec_done && can_load) begin
      code_d[127:0] = rec_word;
      loaded_d      = loaded_q + CW'(1);
    end

    // The shared down-counter is reloaded on every timed-state entry.
    if ((state_d == CLEAR) && (state_q != CLEAR)) begin
      cnt_d         = CNT_W'(CLR_CYC - 1);
      mask_d        = '0;
      loaded_d      = '0;
      pending_d     = 1'b0;
      code_d[127:0] = '0;
`ifdef CHEAT_LOADER_STATUS_EN
      overflow_d    = 1'b0;
`endif
    end else if ((state_d == STROBE_HI) && (state_q != STROBE_HI)) begin
      cnt_d = CNT_W'(STROBE_CYC - 1);
    end else if ((state_d == STROBE_LO) && (state_q != STROBE_LO)) begin
      cnt_d = CNT_W'(STROBE_CYC - 1);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    code_d[CLK_BIT] = (state_d == STROBE_HI);
    codes_reset_d   = (state_d == CLEAR);
    wait_d          = (state_d == STROBE_HI) || (state_d == STROBE_LO);
  end

  assign code        = code_q;
  assign codes_reset = codes_reset_q;
  assign ioctl_wait  = wait_q;
`ifdef CHEAT_LOADER_STATUS_EN
  assign code_count  = loaded_q;
  assign overflow    = overflow_q;
`endif

endmodule

// File: doc/cheat_loader.md
Name: cheat_loader

Overview:
- Upstream feeder for the cheat-code matching engine.
- Consumes the HPS file-download stream (ioctl bus, 16-bit words) for the cheat file. Assembles each 16-byte record into the 129-bit code word.
- Presents each code with a paced clock-bit pulse on code[128] so the engine registers exactly one code per pulse.
- Issues a clear pulse to the engine when a new cheat download starts, and stalls the HPS with ioctl_wait while a pulse is in progress.

Parameters:
- CHEAT_INDEX, 8'd255, ioctl_index value identifying the cheat file.
- MAX_CODES, 32, number of records forwarded per download; later records are dropped.
- STROBE_CYC, 4, cycles code[128] is held high, and then held low, per record (min 1).
- CLR_CYC, 2, cycles codes_reset is held high at download start (min 1).

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- ioctl_download  in  1  download active.
- ioctl_index  in  8  file index.
- ioctl_wr  in  1  one-cycle write strobe.
- ioctl_addr  in  25  byte address, always even.
- ioctl_dout  in  16  data word, little-endian byte pair.
- ioctl_wait  out  1  stall request to HPS.
- code  out  129  {clock bit, flags, address, compare, replace} to the engine.
- codes_reset  out  1  clear pulse to the engine.

Behaviour:
- Reset values: code=0, codes_reset=0, ioctl_wait=0, state=IDLE, word mask=0, loaded count=0, pending-start=0. Reset mid-strobe drops code[128] to 0 on the next cycle.
- active = ioctl_download && (ioctl_index==CHEAT_INDEX). A start is the rising edge of active, registered against its previous value.
- States:
  - IDLE:
    - start -> CLEAR. CLEAR entry zeroes the word mask and the loaded count, and sets codes_reset.
  - CLEAR:
    - codes_reset=1 for CLR_CYC cycles, then -> COLLECT.
    - code[127:0] is zeroed on entry.
  - COLLECT:
    - Accepts ioctl_wr only while active.
    - Word slot w = ioctl_addr[3:1]; store ioctl_dout into slot w and set mask[w].
    - File byte order: flags = {b3,b2,b1,b0}, address = {b7..b4}, compare = {b11..b8}, replace = {b15..b12}, where b(2k) = dout[7:0] and b(2k+1) = dout[15:8] of slot k.
    - Each 32-bit field is byte-swapped from file little-endian into the big-endian bit layout: flags -> code[127:96], address -> code[95:64], compare -> code[63:32], replace -> code[31:0].
  - Record completion:
    - A write to w=7 with all of mask[6:0] set completes a record.
    - If loaded count < MAX_CODES: on the next edge latch the assembled 128 bits into code[127:0], set code[128]=1 and ioctl_wait=1, increment count, then -> STROBE_HI.
    - Otherwise drop the record silently: no pulse, no wait.
    - Mask clears on any w=7 write, complete or not.
    - A w=7 write with an incomplete mask is dropped.
  - STROBE_HI:
    - code[128]=1 and ioctl_wait=1 for STROBE_CYC cycles, then -> STROBE_LO.
  - STROBE_LO:
    - code[128]=0 and ioctl_wait=1 for STROBE_CYC cycles.
    - ioctl_wait drops on the last cycle, then -> COLLECT.
    - If pending-start is set, go to CLEAR instead (pending-start clears).
- code[127:0] stays stable from latch until the next record latch or CLEAR; it never changes while code[128]=1.
- An ioctl_wr arriving in STROBE_*, CLEAR or IDLE is ignored. The bench flags it as a protocol violation.
- Active falls in COLLECT -> IDLE. Any partial record is discarded, and count and code are retained.
- Active falls during STROBE_* -> the strobe completes, then -> IDLE.
- A start edge during STROBE_* sets pending-start; CLEAR runs after STROBE_LO finishes.
- Any non-cheat ioctl_index is ignored entirely.

Optional Feature:
- Macro CHEAT_LOADER_STATUS_EN.
- Defined: adds output code_count [$clog2(MAX_CODES+1)] (number of records forwarded) and output overflow (sticky; set when a complete record is dropped because count==MAX_CODES). Both clear on reset and on CLEAR entry.
- Undefined: neither port exists. Internal count and drop behaviour are unchanged.

Decomposition:
- Package cheat_pkg holds:
  - state enum {IDLE, CLEAR, COLLECT, STROBE_HI, STROBE_LO};
  - code-word bit-position localparams (CLK_BIT=128, FLAGS_LSB=96, ADDR_LSB=64, COMP_LSB=32, DATA_LSB=0), shared with the matching engine;
  - function swap32 for the little-to-big-endian field reorder.
- No sub-module: one FSM plus a shared down-counter for CLR_CYC/STROBE_CYC.

Test Plan:
- Reset, then start a download on index 255 -> codes_reset high exactly 2 cycles, code=0, ioctl_wait=0.
- Write words 0..7 = 16'h0201,16'h0403,... through 16'h100F -> code[127:96]=32'h04030201, code[31:0]=32'h100F0E0D; code[128] high 4 then low 4 cycles; ioctl_wait high for all 8 of those cycles.
- Write 33 complete records -> exactly 32 strobes; with CHEAT_LOADER_STATUS_EN, code_count=32 and overflow=1.
- Write words 0..5 then drop ioctl_download -> no strobe, code unchanged, state IDLE. A new download -> codes_reset pulse, and code_count=0 (status build).
- Assert reset on the 2nd cycle of STROBE_HI -> code[128]=0 and ioctl_wait=0 on the next cycle, code=0.
- Download with ioctl_index=1 and full records -> no codes_reset, no strobes, ioctl_wait never asserted.
